// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD display-writer arbitration slice.
// State encoding, well-known message IDs and the default 50 MHz dwell time.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_BUSY,
    WAIT_DONE,
    DWELL
  } lcd_state_e;

  localparam int SRC_W = 3;

  localparam logic [7:0] MSG_ESTADO = 8'h01;
  localparam logic [7:0] MSG_OPCODE = 8'h02;
  localparam logic [7:0] MSG_HALT   = 8'h03;
  localparam logic [7:0] MSG_ERR    = 8'h04;

  // One second on screen at 50 MHz
  localparam int DEFAULT_DWELL_CYCLES = 50_000_000;

  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx,
                                               input int n_req);
    if (int'(idx) + 1 >= n_req) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Shared by the arbiters that multiplex a single resource between sources.
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lcd_req_arbiter.sv
// Round-robin arbiter sharing the LCD display writer between message sources.
// Optional build macro LCD_PRIO0_PREEMPT_EN makes source 0 urgent (preempts dwell).
module lcd_req_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MSG_W        = 8,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int DWELL_W      = 26,
  parameter int BUSY_TO      = 255
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [N_REQ-1:0]       iREQ,
  input  logic [N_REQ*MSG_W-1:0] iMSG,
  output logic [N_REQ-1:0]       oACK,
  output logic                   oLCD_START,
  output logic [MSG_W-1:0]       oLCD_MSG,
  input  logic                   iLCD_BUSY,
  output logic [SRC_W-1:0]       oSRC,
  output logic                   oIDLE,
  output logic                   oERR
);

  localparam logic [7:0]         BUSY_LAST  = 8'(BUSY_TO - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0   = N_REQ'(1);

  lcd_state_e         state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         busy_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
  logic [MSG_W-1:0]   msg_q;
  logic [SRC_W-1:0]   src_q;
  logic               idle_q;
  logic               grant_en;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   pick_winner;
  logic               pick_valid;

  lcd_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (iREQ),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    start_d   = 1'b0;
    err_d     = 1'b0;
    grant_en  = 1'b0;
    grant_idx = pick_winner;
    case (state_q)
      IDLE: begin
`ifdef LCD_PRIO0_PREEMPT_EN
        // Urgent source 0 jumps the queue without disturbing the rotation
        if (iREQ[0]) begin
          grant_en  = 1'b1;
          grant_idx = '0;
        end else if (pick_valid) begin
          grant_en = 1'b1;
          rr_ptr_d = rr_next(pick_winner, N_REQ);
        end
`else
        if (pick_valid) begin
          grant_en = 1'b1;
          rr_ptr_d = rr_next(pick_winner, N_REQ);
        end
`endif
        if (grant_en) begin
          state_d = GRANT;
          ack_d   = ONE_HOT0 << grant_idx;
          start_d = 1'b1;
        end
      end
      GRANT: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (iLCD_BUSY) begin
          state_d = WAIT_DONE;
        end else if (busy_cnt_q >= BUSY_LAST) begin
          err_d   = 1'b1;
          state_d = DWELL;
        end
      end
      WAIT_DONE: begin
        if (!iLCD_BUSY) state_d = DWELL;
      end
      DWELL: begin
        if (dwell_cnt_q >= DWELL_LAST) state_d = IDLE;
`ifdef LCD_PRIO0_PREEMPT_EN
        else if (iREQ[0]) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Counters restart on every state change and saturate instead of wrapping
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busy_cnt_q  <= '0;
      dwell_cnt_q <= '0;
    end else if (state_d != state_q) begin
      busy_cnt_q  <= '0;
      dwell_cnt_q <= '0;
    end else begin
      if (state_q == WAIT_BUSY && busy_cnt_q != '1)
        busy_cnt_q <= busy_cnt_q + 8'd1;
      if (state_q == DWELL && dwell_cnt_q != '1)
        dwell_cnt_q <= dwell_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr_ptr_q <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      msg_q    <= '0;
      src_q    <= '0;
      idle_q   <= 1'b1;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      err_q    <= err_d;
      idle_q   <= (state_d == IDLE);
      if (grant_en) begin
        msg_q <= iMSG[int'(grant_idx)*MSG_W +: MSG_W];
        src_q <= grant_idx;
      end
    end
  end

  assign oACK       = ack_q;
  assign oLCD_START = start_q;
  assign oLCD_MSG   = msg_q;
  assign oSRC       = src_q;
  assign oIDLE      = idle_q;
  assign oERR       = err_q;

endmodule
